// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Owns the framebuffer write port. Two requesters share it: port A, the
//   host/serial loader, and port B, the drawing/scroll engine. They are served
//   round-robin with at most one write per cycle. A clear engine can also
//   sweep every framebuffer address with CLEAR_VALUE.
//
//   Ports
//     clk, reset                 single clock; synchronous active-high reset
//     a_valid/a_ready/a_addr/a_data   port A request (transfer = valid & ready)
//     b_valid/b_ready/b_addr/b_data   port B request
//     clear_req                  start a clear sweep (level, sampled in IDLE)
//     clear_busy                 high while sweeping
//     wr_enable/wr_addr/wr_data  registered framebuffer write port; a write
//                                issued in cycle t appears in cycle t+1
module fb_write_arbiter #(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           NUM_BYTES   = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  wr_enable,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  // One extra counter bit so a sweep of the full 2^ADDR_WIDTH space can
  // still compare against its last index without wrapping.
  localparam int unsigned          CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(NUM_BYTES - 1);

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic {GRANT_A, GRANT_B} grant_t;

  state_t                state, state_next;
  grant_t                last_grant, last_grant_next;
  logic [CNT_WIDTH-1:0]  count, count_next;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [DATA_WIDTH-1:0] issue_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_B;
      count      <= '0;
      wr_enable  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      count      <= count_next;
      wr_enable  <= issue;
      if (issue) begin
        wr_addr <= issue_addr;
        wr_data <= issue_data;
      end
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    count_next      = count;
    a_ready         = 1'b0;
    b_ready         = 1'b0;
    clear_busy      = 1'b0;
    issue           = 1'b0;
    issue_addr      = '0;
    issue_data      = '0;

    unique case (state)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
          count_next = '0;
        end else if (a_valid && (!b_valid || last_grant == GRANT_B)) begin
          // A wins when alone, or on a tie when B was served last.
          a_ready         = 1'b1;
          issue           = 1'b1;
          issue_addr      = a_addr;
          issue_data      = a_data;
          last_grant_next = GRANT_A;
        end else if (b_valid) begin
          b_ready         = 1'b1;
          issue           = 1'b1;
          issue_addr      = b_addr;
          issue_data      = b_data;
          last_grant_next = GRANT_B;
        end
      end
      CLEAR: begin
        clear_busy = 1'b1;
        issue      = 1'b1;
        issue_addr = count[ADDR_WIDTH-1:0];
        issue_data = CLEAR_VALUE;
        count_next = count + 1'b1;
        if (count == CNT_LAST) begin
          state_next = IDLE;
        end
      end
    endcase

    // No handshake may complete in a cycle that is being reset.
    if (reset) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int          NB = 16;
  localparam logic [DW-1:0] CV = 8'hFF;

  localparam int S_AR = 0, S_BR = 1, S_CB = 2, S_WE = 3, S_WA = 4, S_WD = 5, S_MEM = 6;

  bit clk;
  logic reset, a_valid, b_valid, clear_req;
  logic a_ready, b_ready, clear_busy, wr_enable;
  logic [AW-1:0] a_addr, b_addr, wr_addr;
  logic [DW-1:0] a_data, b_data, wr_data;

  fb_write_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_BYTES  (NB),
    .CLEAR_VALUE(CV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .wr_enable (wr_enable),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  // ---------------- shared bookkeeping ----------------
  typedef struct {
    int          cyc;
    int          sel;
    int          addr;
    logic [31:0] expv;
    string       name;
  } pin_t;

  pin_t pins[$];          // written by stimulus only
  int   rb_req = 0;       // written by stimulus only
  int   rb_ack = 0;       // written by compare only
  int   cyc = 0;          // written by compare only
  int   checks = 0;
  int   errors = 0;

  // ---------------- behavioural model state (compare process only) -------
  logic [DW-1:0] fb_dut[NB];
  logic [DW-1:0] fb_exp[NB];
  bit            mem_init = 0;
  bit            model_ok = 0;
  int            m_left = 0;      // clear words still to issue; 0 = not clearing
  int            m_addr = 0;      // next clear address
  bit            m_last_b = 1;    // most recent grant went to B
  bit            p_en = 0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_data = '0;
  bit            e_ar, e_br, blk;

  function automatic logic [31:0] get_sig(input int sel, input int ad);
    case (sel)
      S_AR:    return {31'b0, a_ready};
      S_BR:    return {31'b0, b_ready};
      S_CB:    return {31'b0, clear_busy};
      S_WE:    return {31'b0, wr_enable};
      S_WA:    return {28'b0, wr_addr};
      S_WD:    return {24'b0, wr_data};
      S_MEM:   return {24'b0, fb_dut[AW'(ad)]};
      default: return 'x;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < NB; i++) begin
        fb_dut[i] = DW'($urandom);
        fb_exp[i] = fb_dut[i];
      end
      mem_init = 1;
    end
    if (wr_enable === 1'b1) fb_dut[wr_addr] = wr_data;

    blk  = reset || (m_left != 0) || clear_req;
    e_ar = !blk && a_valid && (!b_valid || m_last_b);
    e_br = !blk && b_valid && (!a_valid || !m_last_b);

    if (model_ok) begin
      chk("a_ready",    {31'b0, a_ready},    {31'b0, e_ar});
      chk("b_ready",    {31'b0, b_ready},    {31'b0, e_br});
      chk("clear_busy", {31'b0, clear_busy}, {31'b0, m_left != 0});
      chk("wr_enable",  {31'b0, wr_enable},  {31'b0, p_en});
      chk("wr_addr",    {28'b0, wr_addr},    {28'b0, p_addr});
      chk("wr_data",    {24'b0, wr_data},    {24'b0, p_data});
    end

    foreach (pins[i])
      if (pins[i].cyc == cyc)
        chk(pins[i].name, get_sig(pins[i].sel, pins[i].addr), pins[i].expv);

    if (rb_ack != rb_req) begin
      for (int i = 0; i < NB; i++)
        chk($sformatf("readback[%0d]", i), {24'b0, fb_dut[i]}, {24'b0, fb_exp[i]});
      rb_ack = rb_req;
    end

    if (reset) begin
      m_left = 0; p_en = 0; p_addr = '0; p_data = '0; m_last_b = 1; model_ok = 1;
    end else if (model_ok) begin
      if (m_left != 0) begin
        p_en = 1; p_addr = AW'(m_addr); p_data = CV;
        fb_exp[AW'(m_addr)] = CV;
        m_addr++; m_left--;
      end else if (clear_req) begin
        m_left = NB; m_addr = 0; p_en = 0;
      end else if (e_ar) begin
        p_en = 1; p_addr = a_addr; p_data = a_data; fb_exp[a_addr] = a_data; m_last_b = 0;
      end else if (e_br) begin
        p_en = 1; p_addr = b_addr; p_data = b_data; fb_exp[b_addr] = b_data; m_last_b = 1;
      end else begin
        p_en = 0;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input int c, input int sel, input logic [31:0] v, input string nm,
                     input int ad = 0);
    pin_t p;
    p.cyc = c; p.sel = sel; p.addr = ad; p.expv = v; p.name = nm;
    pins.push_back(p);
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic a_write(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_valid = 1; a_addr = ad; a_data = d;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (a_ready) begin
        tick();
        a_valid = 0;
        return;
      end
      tick();
    end
    $display("FAIL a_write timeout: a_ready never rose, required 1");
    $fatal(1);
  endtask

  task automatic readback();
    rb_req++;
    for (int i = 0; i < 5 && rb_ack != rb_req; i++) tick();
    if (rb_ack != rb_req) begin
      $display("FAIL readback not serviced: ack %0d required %0d", rb_ack, rb_req);
      $fatal(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  initial begin
    int t;
    bit acc_a, acc_b;
    reset = 1; a_valid = 0; b_valid = 0; clear_req = 0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    tick();
    do_reset();

    // Single A write
    t = cyc;
    a_valid = 1; a_addr = 4'hC; a_data = 8'h5A;
    pin(t, S_AR, 1, "single_a_ready");
    pin(t, S_BR, 0, "single_b_ready");
    pin(t + 1, S_WE, 1, "single_we");
    pin(t + 1, S_WA, 32'hC, "single_addr");
    pin(t + 1, S_WD, 32'h5A, "single_data");
    pin(t + 2, S_WE, 0, "single_we_off");
    tick(); a_valid = 0;
    tick(); tick();

    // Contention right after reset: A, B, A, B, then A alone
    do_reset();
    t = cyc;
    a_valid = 1; a_addr = 4'h1; a_data = 8'h11;
    b_valid = 1; b_addr = 4'h2; b_data = 8'h22;
    for (int k = 0; k < 5; k++) begin
      pin(t + k, S_AR, (k % 2 == 0) ? 1 : 0, $sformatf("rr_a_ready_%0d", k));
      pin(t + k, S_BR, (k % 2 == 1) ? 1 : 0, $sformatf("rr_b_ready_%0d", k));
      pin(t + k + 1, S_WE, 1, $sformatf("rr_we_%0d", k));
      pin(t + k + 1, S_WA, k + 1, $sformatf("rr_addr_%0d", k));
    end
    tick(); a_addr = 4'h3; a_data = 8'h33;
    tick(); b_addr = 4'h4; b_data = 8'h44;
    tick(); a_addr = 4'h5; a_data = 8'h55;
    tick(); b_valid = 0;
    tick(); a_valid = 0;
    tick(); tick();

    // Clear pulse together with an A request: A waits out the sweep
    t = cyc;
    clear_req = 1; a_valid = 1; a_addr = 4'h7; a_data = 8'h33;
    pin(t, S_AR, 0, "clr_a_blocked");
    pin(t, S_CB, 0, "clr_busy_start");
    for (int k = 1; k <= 16; k++) begin
      pin(t + k, S_CB, 1, $sformatf("clr_busy_%0d", k));
      pin(t + k, S_AR, 0, $sformatf("clr_a_wait_%0d", k));
      pin(t + k + 1, S_WE, 1, $sformatf("clr_we_%0d", k - 1));
      pin(t + k + 1, S_WA, k - 1, $sformatf("clr_addr_%0d", k - 1));
      pin(t + k + 1, S_WD, 32'hFF, $sformatf("clr_data_%0d", k - 1));
    end
    pin(t + 17, S_CB, 0, "clr_busy_end");
    pin(t + 17, S_AR, 1, "clr_a_after");
    pin(t + 18, S_WE, 1, "clr_a_we");
    pin(t + 18, S_WA, 32'h7, "clr_a_addr");
    pin(t + 18, S_WD, 32'h33, "clr_a_data");
    tick(); clear_req = 0;
    repeat (17) tick();
    a_valid = 0;
    tick(); tick();

    // Prefill, then abort a clear with reset in its fifth cycle
    for (int i = 0; i < NB; i++) a_write(AW'(i), DW'(8'h40 + i));
    tick(); tick();
    t = cyc;
    clear_req = 1;
    tick(); clear_req = 0;
    repeat (4) tick();
    reset = 1;
    pin(t + 5, S_CB, 1, "abort_busy_before");
    pin(t + 5, S_WA, 32'h3, "abort_last_addr");
    pin(t + 6, S_WE, 0, "abort_we");
    pin(t + 6, S_CB, 0, "abort_busy");
    tick(); reset = 0;
    tick(); tick();
    pin(cyc, S_MEM, 32'hFF, "abort_mem0", 0);
    pin(cyc, S_MEM, 32'hFF, "abort_mem3", 3);
    pin(cyc, S_MEM, 32'h44, "abort_mem4", 4);
    pin(cyc, S_MEM, 32'h4F, "abort_mem15", 15);
    readback();

    // clear_req held through a whole sweep: a second sweep follows
    t = cyc;
    clear_req = 1; a_valid = 1; a_addr = 4'h9; a_data = 8'h99;
    pin(t + 17, S_CB, 0, "hold_gap_busy");
    pin(t + 17, S_AR, 0, "hold_gap_a");
    pin(t + 17, S_WE, 1, "hold_last_we");
    pin(t + 18, S_WE, 0, "hold_gap_we");
    pin(t + 18, S_CB, 1, "hold_second_busy");
    pin(t + 19, S_WE, 1, "hold_second_we");
    pin(t + 19, S_WA, 0, "hold_second_addr");
    pin(t + 34, S_AR, 1, "hold_a_after");
    pin(t + 35, S_WA, 32'h9, "hold_a_addr");
    repeat (18) tick();
    clear_req = 0;
    repeat (17) tick();
    a_valid = 0;
    tick(); tick();

    // Randomized traffic with occasional clears and resets
    acc_a = 0; acc_b = 0;
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      clear_req = ($urandom_range(0, 59) == 0);
      if (!a_valid || acc_a) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_addr  = AW'($urandom);
        a_data  = DW'($urandom);
      end
      if (!b_valid || acc_b) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_addr  = AW'($urandom);
        b_data  = DW'($urandom);
      end
      #2;
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      tick();
    end
    reset = 0; clear_req = 0; a_valid = 0; b_valid = 0;
    for (int i = 0; i < 40 && clear_busy; i++) tick();
    if (clear_busy) begin
      $display("FAIL drain: clear_busy still 1, required 0");
      $fatal(1);
    end
    tick(); tick(); tick();
    readback();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Owns the framebuffer RAM write port (wr_enable/wr_addr/wr_data) and shares it between two requesters.
  - Port A: serial/host loader.
  - Port B: on-chip drawing/scroll engine.
- Also contains a clear engine that sweeps every framebuffer address with a fixed value on command.
- Sits between the requesters and the framebuffer write domain; the read/scan-out side is untouched.
- Guarantees at most one write per cycle and fair round-robin service.

Parameters:
ADDR_WIDTH, 8, framebuffer address width
DATA_WIDTH, 8, framebuffer word width
NUM_BYTES, 1<<ADDR_WIDTH, number of words swept by clear (1..2^ADDR_WIDTH)
CLEAR_VALUE, 0, word written to every address during clear

Ports:
clk  in  1  single clock; also drives the framebuffer write clock
reset  in  1  synchronous, active-high reset
a_valid  in  1  port A write request
a_ready  out  1  port A accepted this cycle (transfer = a_valid & a_ready)
a_addr  in  ADDR_WIDTH  port A address
a_data  in  DATA_WIDTH  port A data
b_valid  in  1  port B write request
b_ready  out  1  port B accepted this cycle
b_addr  in  ADDR_WIDTH  port B address
b_data  in  DATA_WIDTH  port B data
clear_req  in  1  start clear sweep (level sampled in IDLE)
clear_busy  out  1  high while in CLEAR state
wr_enable  out  1  framebuffer write strobe (registered)
wr_addr  out  ADDR_WIDTH  framebuffer write address (registered)
wr_data  out  DATA_WIDTH  framebuffer write data (registered)

Behaviour:
- Reset values (synchronous, active-high): state=IDLE, wr_enable=0, wr_addr=0, wr_data=0, clear counter=0, last_grant=B (so A wins first tie).
- a_ready, b_ready and clear_busy are combinational from state, last_grant, valids and clear_req. wr_* are registers.
- Latency: a transfer accepted in cycle t drives wr_enable=1 with its addr/data in cycle t+1. Cycles with no issue drive wr_enable=0. wr_addr/wr_data hold their last value.
- IDLE arbitration, per cycle:
  - clear_req=1: a_ready=b_ready=0; next state CLEAR, counter<=0. Clear has priority over pending requests.
  - Else only one valid: that port's ready=1.
  - Else both valid: grant the port not equal to last_grant.
  - last_grant updates only on an actual transfer.
  - ready is never asserted for a port whose valid is low.
  - Requesters must hold valid/addr/data stable until ready.
- CLEAR state:
  - a_ready=b_ready=0 and clear_busy=1.
  - Each cycle issue addr=counter, data=CLEAR_VALUE; counter++.
  - On the cycle issuing NUM_BYTES-1, next state is IDLE.
  - The clear occupies exactly NUM_BYTES cycles. Writes appear on the bus one cycle later (addresses 0..NUM_BYTES-1 ascending, no gaps).
  - The counter is ADDR_WIDTH+1 bits wide so NUM_BYTES=2^ADDR_WIDTH terminates correctly; wr_addr takes the low ADDR_WIDTH bits.
- clear_req while in CLEAR is ignored (no restart, no queued second clear). clear_req still high on return to IDLE starts a new sweep.
- The first requester transfer after a clear can be accepted in the cycle after the last CLEAR cycle. Its write is back-to-back with the last clear write.
- Reset mid-clear: aborts immediately. Next cycle wr_enable=0, state=IDLE. Already-written words stay cleared; remaining words are untouched.
- Reset with a pending request: no transfer in the reset cycle (readys 0 while reset=1).
- Simultaneous A/B writes to the same address: serialized in grant order; the later grant's data is final.

Test Plan:
- Single A: reset, then a_valid=1 with a_addr=0x12, a_data=0x5A for one accepted cycle t -> a_ready=1 at t; wr_enable=1, wr_addr=0x12, wr_data=0x5A at t+1 only.
- Contention: A and B both valid continuously for 4 cycles after reset -> grants A,B,A,B. Bus shows alternating addresses one cycle later. No idle bus cycles.
- Clear (ADDR_WIDTH=4, CLEAR_VALUE=0xFF), one-cycle clear_req pulse at t:
  - clear_busy high t+1..t+16.
  - wr_enable high t+2..t+17 with addr 0..15, data 0xFF.
  - a_valid held throughout: first accepted at t+17, written at t+18.
- clear_req and a_valid asserted together in IDLE -> a_ready=0 that cycle. Clear starts; A is served after the sweep.
- Reset at 5th CLEAR cycle -> wr_enable=0 next cycle, clear_busy=0. Readback shows addrs 0..3 = CLEAR_VALUE and the rest unchanged.
- clear_req held high through an entire sweep -> a second full sweep follows immediately. No requester is accepted between sweeps.
